// File: rtl/regfile_sb_if.sv
// Register-file/scoreboard bus: read ports, two write ports, issue handshake, error flag.
// Widths follow DATA_W and NRD of the attached regfile_sb instance.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int NRD    = 2
);
  logic [5*NRD-1:0]      raddr;
  logic [DATA_W*NRD-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  we0;
  logic                  we1;
  logic [4:0]            waddr0;
  logic [4:0]            waddr1;
  logic [DATA_W-1:0]     wdata0;
  logic [DATA_W-1:0]     wdata1;
  logic                  iss_valid;
  logic [4:0]            iss_addr;
  logic                  iss_ready;
  logic                  err;

  modport master (
    output raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, iss_valid, iss_addr,
    input  rdata, rbusy, iss_ready, err
  );

  modport slave (
    input  raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, iss_valid, iss_addr,
    output rdata, rbusy, iss_ready, err
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-ported register file with a per-register busy scoreboard and sticky error flag.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int NRD    = 2
) (
  input logic          CLK,
  input logic          RESET,
  regfile_sb_if.slave  bus
);

  localparam logic [5:0] DEPTH6 = 6'(DEPTH);

  function automatic logic in_range(input logic [4:0] a);
    return {1'b0, a} < DEPTH6;
  endfunction

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy;
  logic                         err_q;

  logic [DEPTH-1:0] hit_w0;
  logic [DEPTH-1:0] hit_w1;
  logic [DEPTH-1:0] hit_iss;
  logic [DEPTH-1:0] iss_set;
  logic             iss_ok;
  logic             wr_oob;
  logic             wr_idle;
  logic             wr_clash;
  logic             werr;

  // One-hot address decodes; out-of-range addresses decode to all zeros.
  always_comb begin
    hit_w0  = '0;
    hit_w1  = '0;
    hit_iss = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_w0[i]  = bus.we0 && (bus.waddr0 == 5'(i));
      hit_w1[i]  = bus.we1 && (bus.waddr1 == 5'(i));
      hit_iss[i] = (bus.iss_addr == 5'(i));
    end
  end

  // Issue acceptance looks only at current busy state, so a register being freed this cycle is accepted next cycle.
  always_comb begin
    iss_ok   = bus.iss_valid && !RESET && (|(hit_iss & ~busy));
    iss_set  = hit_iss & {DEPTH{iss_ok}};
    wr_oob   = (bus.we0 && !in_range(bus.waddr0)) || (bus.we1 && !in_range(bus.waddr1));
    wr_idle  = (|(hit_w0 & ~busy)) || (|(hit_w1 & ~busy));
    wr_clash = bus.we0 && bus.we1 && (bus.waddr0 == bus.waddr1);
    werr     = wr_oob || wr_idle || wr_clash;
  end

  assign bus.iss_ready = iss_ok;
  assign bus.err       = err_q;

  // Register storage; port 1 takes priority when both ports hit the same register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (hit_w1[i])      mem[i] <= bus.wdata1;
        else if (hit_w0[i]) mem[i] <= bus.wdata0;
      end
    end
  end

  // Scoreboard: writes clear, accepted issues set, and a set beats a clear on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) busy <= '0;
    else       busy <= iss_set | (busy & ~(hit_w0 | hit_w1));
  end

  // Sticky protocol error.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     err_q <= 1'b0;
    else if (werr) err_q <= 1'b1;
  end

  // Read ports: stored contents, optionally overridden by same-cycle write data.
  always_comb begin
    logic [4:0] ra;
    ra        = '0;
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = bus.raddr[5*k +: 5];
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ra == 5'(i)) begin
          bus.rdata[DATA_W*k +: DATA_W] = mem[i];
          bus.rbusy[k]                  = busy[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (!RESET && in_range(ra)) begin
        if (bus.we0 && (bus.waddr0 == ra)) begin
          bus.rdata[DATA_W*k +: DATA_W] = bus.wdata0;
          bus.rbusy[k]                  = 1'b0;
        end
        if (bus.we1 && (bus.waddr1 == ra)) begin
          bus.rdata[DATA_W*k +: DATA_W] = bus.wdata1;
          bus.rbusy[k]                  = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int NRD    = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_sb_if #(.DATA_W(DATA_W), .NRD(NRD)) bus ();

  regfile_sb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  bit          m_err;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic bit valid_addr(input logic [4:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    if (!valid_addr(a)) return '0;
    if (BYP && bus.we1 && bus.waddr1 == a) return bus.wdata1;
    if (BYP && bus.we0 && bus.waddr0 == a) return bus.wdata0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rbusy(input logic [4:0] a);
    if (!valid_addr(a)) return 1'b0;
    if (BYP && ((bus.we1 && bus.waddr1 == a) || (bus.we0 && bus.waddr0 == a))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_iss_ready();
    return bus.iss_valid && valid_addr(bus.iss_addr) && !m_busy[bus.iss_addr];
  endfunction

  // Apply the rules of one clock edge to the model, using the inputs currently driven.
  task automatic model_step();
    bit ir;
    ir = exp_iss_ready();
    if (bus.we0 && (!valid_addr(bus.waddr0) || !m_busy[bus.waddr0])) m_err = 1'b1;
    if (bus.we1 && (!valid_addr(bus.waddr1) || !m_busy[bus.waddr1])) m_err = 1'b1;
    if (bus.we0 && bus.we1 && bus.waddr0 == bus.waddr1) m_err = 1'b1;
    if (bus.we0 && valid_addr(bus.waddr0)) begin
      m_mem[bus.waddr0]  = bus.wdata0;
      m_busy[bus.waddr0] = 1'b0;
    end
    if (bus.we1 && valid_addr(bus.waddr1)) begin
      m_mem[bus.waddr1]  = bus.wdata1;
      m_busy[bus.waddr1] = 1'b0;
    end
    if (ir) m_busy[bus.iss_addr] = 1'b1;
  endtask

  task automatic idle();
    bus.raddr     = '0;
    bus.we0       = 1'b0;
    bus.we1       = 1'b0;
    bus.waddr0    = '0;
    bus.waddr1    = '0;
    bus.wdata0    = '0;
    bus.wdata1    = '0;
    bus.iss_valid = 1'b0;
    bus.iss_addr  = '0;
  endtask

  task automatic tick();
    if (!rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.raddr     = {5'd3, 5'd2};
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd2;
    bus.we0       = 1'b1;
    bus.waddr0    = 5'd2;
    bus.wdata0    = 32'h5;
    #2;
    n_checks++;
    if (bus.rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    n_checks++;
    if (bus.rbusy !== 2'b00) begin n_fail++; $display("FAIL reset_rbusy: got %b expected 00", bus.rbusy); end
    n_checks++;
    if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL reset_iss_ready: got %b expected 0", bus.iss_ready); end
    n_checks++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_write_ignored: got %h expected 0", bus.rdata[31:0]); end
    idle();
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.raddr = {5'd0, 5'd2};
    #1;
    n_checks++;
    if (bus.rdata[31:0] !== 32'h0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got rdata %h err %b expected 0 0", bus.rdata[31:0], bus.err);
    end
  endtask

  task automatic test_issue_write();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd5;
    bus.raddr     = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready: got %b expected 1", bus.iss_ready); end
    tick();
    idle();
    bus.we0    = 1'b1;
    bus.waddr0 = 5'd5;
    bus.wdata0 = 32'h12;
    bus.raddr  = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (bus.rbusy[0] !== !BYP) begin n_fail++; $display("FAIL issue_busy_set: got %b expected %b", bus.rbusy[0], !BYP); end
    tick();
    idle();
    bus.raddr = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (bus.rbusy[0] !== 1'b0 || bus.rdata[31:0] !== 32'h12 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL issue_write_done: got busy %b data %h err %b expected 0 00000012 0", bus.rbusy[0], bus.rdata[31:0], bus.err);
    end
  endtask

  task automatic test_set_wins();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd4;
    tick();
    idle();
    bus.we0       = 1'b1;
    bus.waddr0    = 5'd4;
    bus.wdata0    = 32'h44;
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd4;
    bus.raddr     = {5'd4, 5'd4};
    #1;
    n_checks++;
    if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL busy_issue_blocked: got %b expected 0", bus.iss_ready); end
    tick();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd4;
    bus.raddr     = {5'd4, 5'd4};
    #1;
    n_checks++;
    if (bus.rbusy[0] !== 1'b0 || bus.iss_ready !== 1'b1 || bus.rdata[31:0] !== 32'h44) begin
      n_fail++; $display("FAIL reissue_ready: got busy %b ready %b data %h expected 0 1 00000044", bus.rbusy[0], bus.iss_ready, bus.rdata[31:0]);
    end
    tick();
    idle();
    bus.raddr = {5'd4, 5'd4};
    #1;
    n_checks++;
    if (bus.rbusy[1] !== 1'b1 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reissue_busy: got busy %b err %b expected 1 0", bus.rbusy[1], bus.err);
    end
    // clear and set of the same idle register on one edge: set wins, err raised
    idle();
    bus.we1       = 1'b1;
    bus.waddr1    = 5'd6;
    bus.wdata1    = 32'h66;
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd6;
    #1;
    n_checks++;
    if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL setwins_ready: got %b expected 1", bus.iss_ready); end
    tick();
    idle();
    bus.raddr = {5'd6, 5'd6};
    #1;
    n_checks++;
    if (bus.rbusy !== 2'b11 || bus.rdata[63:32] !== 32'h66 || bus.err !== 1'b1) begin
      n_fail++; $display("FAIL setwins_state: got busy %b data %h err %b expected 11 00000066 1", bus.rbusy, bus.rdata[63:32], bus.err);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.we0    = 1'b1;
    bus.waddr0 = 5'd9;
    bus.wdata0 = 32'h55;
    tick();
    idle();
    bus.we1    = 1'b1;
    bus.waddr1 = 5'd9;
    bus.wdata1 = 32'hAA;
    bus.raddr  = {5'd0, 5'd9};
    #1;
    n_checks++;
    if (bus.rdata[31:0] !== (BYP ? 32'hAA : 32'h55)) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", bus.rdata[31:0], BYP ? 32'hAA : 32'h55);
    end
    tick();
    idle();
    bus.raddr = {5'd0, 5'd9};
    #1;
    n_checks++;
    if (bus.rdata[31:0] !== 32'hAA) begin n_fail++; $display("FAIL bypass_next_cycle: got %h expected 000000aa", bus.rdata[31:0]); end
  endtask

  task automatic test_collision();
    do_reset();
    bus.we0    = 1'b1;
    bus.waddr0 = 5'd7;
    bus.wdata0 = 32'h1;
    bus.we1    = 1'b1;
    bus.waddr1 = 5'd7;
    bus.wdata1 = 32'h2;
    tick();
    idle();
    bus.raddr = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (bus.rdata[31:0] !== 32'h2 || bus.err !== 1'b1) begin
      n_fail++; $display("FAIL collision: got data %h err %b expected 00000002 1", bus.rdata[31:0], bus.err);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd1;
    tick();
    idle();
    bus.we0    = 1'b1;
    bus.waddr0 = 5'd1;
    bus.wdata0 = 32'h11;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL oor_err_before: got %b expected 0", bus.err); end
    bus.we0       = 1'b1;
    bus.waddr0    = 5'd20;
    bus.wdata0    = 32'hBAD0BAD0;
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd20;
    bus.raddr     = {5'd20, 5'd20};
    #1;
    n_checks++;
    if (bus.rdata !== '0 || bus.rbusy !== 2'b00 || bus.iss_ready !== 1'b0) begin
      n_fail++; $display("FAIL oor_read: got data %h busy %b ready %b expected 0 00 0", bus.rdata, bus.rbusy, bus.iss_ready);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.err !== 1'b1) begin n_fail++; $display("FAIL oor_err_after: got %b expected 1", bus.err); end
    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr = {5'(i), 5'(i)};
      #1;
      n_checks++;
      if (bus.rdata[31:0] !== ((i == 1) ? 32'h11 : 32'h0)) begin
        n_fail++; $display("FAIL oor_contents r%0d: got %h expected %h", i, bus.rdata[31:0], (i == 1) ? 32'h11 : 32'h0);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd3;
    tick();
    idle();
    bus.we0       = 1'b1;
    bus.waddr0    = 5'd3;
    bus.wdata0    = 32'hDEADBEEF;
    bus.iss_valid = 1'b1;
    bus.iss_addr  = 5'd8;
    tick();
    idle();
    bus.we1    = 1'b1;
    bus.waddr1 = 5'd10;
    bus.wdata1 = 32'h10;
    tick();
    idle();
    bus.raddr = {5'd8, 5'd3};
    #1;
    n_checks++;
    if (bus.rdata[31:0] !== 32'hDEADBEEF || bus.rbusy !== 2'b10 || bus.err !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: got data %h busy %b err %b expected deadbeef 10 1", bus.rdata[31:0], bus.rbusy, bus.err);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.rdata !== '0 || bus.rbusy !== 2'b00 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: got data %h busy %b err %b expected 0 00 0", bus.rdata, bus.rbusy, bus.err);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [4:0] a0, a1;
    for (int n = 0; n < 600; n++) begin
      idle();
      a0 = 5'($urandom_range(0, 19));
      a1 = 5'($urandom_range(0, 19));
      bus.raddr     = {a1, a0};
      bus.we0       = ($urandom_range(0, 2) == 0);
      bus.we1       = ($urandom_range(0, 3) == 0);
      bus.waddr0    = 5'($urandom_range(0, 19));
      bus.waddr1    = 5'($urandom_range(0, 19));
      bus.wdata0    = $urandom;
      bus.wdata1    = $urandom;
      bus.iss_valid = ($urandom_range(0, 1) == 1);
      bus.iss_addr  = 5'($urandom_range(0, 19));
      #1;
      n_checks++;
      if (bus.rdata[31:0] !== exp_rdata(a0)) begin n_fail++; $display("FAIL rand_rdata0 #%0d: got %h expected %h", n, bus.rdata[31:0], exp_rdata(a0)); end
      n_checks++;
      if (bus.rdata[63:32] !== exp_rdata(a1)) begin n_fail++; $display("FAIL rand_rdata1 #%0d: got %h expected %h", n, bus.rdata[63:32], exp_rdata(a1)); end
      n_checks++;
      if (bus.rbusy !== {exp_rbusy(a1), exp_rbusy(a0)}) begin n_fail++; $display("FAIL rand_rbusy #%0d: got %b expected %b", n, bus.rbusy, {exp_rbusy(a1), exp_rbusy(a0)}); end
      n_checks++;
      if (bus.iss_ready !== exp_iss_ready()) begin n_fail++; $display("FAIL rand_iss_ready #%0d: got %b expected %b", n, bus.iss_ready, exp_iss_ready()); end
      n_checks++;
      if (bus.err !== m_err) begin n_fail++; $display("FAIL rand_err #%0d: got %b expected %b", n, bus.err, m_err); end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    idle();
    test_reset();
    test_issue_write();
    test_set_wins();
    test_bypass();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, number of registers (2..32).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL provide port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL provide port RESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port raddr  input  5*NRD  read addresses; port k = bits [5k+4:5k].
REQ-007 SHALL provide port rdata  output  DATA_W*NRD  read data; port k = bits [DATA_W*k+DATA_W-1:DATA_W*k].
REQ-008 SHALL provide port rbusy  output  NRD  scoreboard busy bit of each read address.
REQ-009 SHALL provide ports we0, we1  input  1 each  write enables, write ports 0 and 1.
REQ-010 SHALL provide ports waddr0, waddr1  input  5 each  write addresses.
REQ-011 SHALL provide ports wdata0, wdata1  input  DATA_W each  write data.
REQ-012 SHALL provide port iss_valid  input  1  request to reserve register iss_addr.
REQ-013 SHALL provide port iss_addr  input  5  register to reserve.
REQ-014 SHALL provide port iss_ready  output  1  reservation accepted this cycle.
REQ-015 SHALL provide port err  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL return rdata combinationally from stored contents; address >= DEPTH reads 0 with rbusy 0.
REQ-017 SHALL write wdataN to register waddrN on the rising edge when weN=1 and waddrN < DEPTH; writes to address >= DEPTH ignored and set err.
REQ-018 SHALL, when we0 and we1 target the same address in one cycle, store wdata1 (port 1 wins) and set err.
REQ-019 SHALL hold one busy bit per register; iss_ready = iss_valid & ~busy[iss_addr] & (iss_addr < DEPTH).
REQ-020 SHALL set busy[iss_addr] on the edge where iss_ready=1.
REQ-021 SHALL clear busy[waddrN] on the edge of a valid write on port N.
REQ-022 SHALL, on simultaneous clear by a write and set by an accepted issue to the same register, leave busy=1 (set wins).
REQ-023 SHALL accept iss_valid to a register whose busy bit is being cleared that cycle only on the following cycle (iss_ready uses current busy state).
REQ-024 SHALL set err on a write to a register whose busy bit is 0; data is still written.
REQ-025 SHALL keep err at 1 until RESET.
REQ-026 SHALL provide single-cycle latency: data written on edge N is readable (without bypass) after edge N.

Reset
REQ-027 SHALL, while RESET=1, asynchronously clear all registers to 0, all busy bits to 0 and err to 0.
REQ-028 SHALL ignore writes and issues while RESET=1; rdata reads 0, iss_ready reads 0.
REQ-029 SHALL resume normal operation on the first rising CLK edge after RESET deasserts.

Configuration
REQ-030 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to any read port whose raddr matches a valid write (port 1 over port 0) and drive rbusy 0 for that port.
REQ-031 SHALL, without REGFILE_BYPASS_EN, return stored contents only; new data and cleared busy become visible after the write edge.

Verification
REQ-032 SHALL verify: RESET pulse mid-run after writing r3=0xDEADBEEF -> r3 reads 0, busy all 0, err 0 immediately, without waiting for CLK.
REQ-033 SHALL verify: issue r5, next cycle we0 r5=0x12 -> rbusy(r5) 1 then 0, rdata 0x12, err 0.
REQ-034 SHALL verify: we0 r7=0x1, we1 r7=0x2 same cycle -> r7=0x2, err=1.
REQ-035 SHALL verify: busy r4, same cycle write r4 and issue r4 -> iss_ready 0; next cycle issue r4 -> iss_ready 1, busy r4=1.
REQ-036 SHALL verify: with REGFILE_BYPASS_EN, raddr0=r9 while we1 r9=0xAA -> rdata0 0xAA same cycle; without macro -> old value, 0xAA next cycle.
REQ-037 SHALL verify: write waddr0=20 with DEPTH=16 -> no register changes, err=1, raddr 20 reads 0.
